// File: rtl/spart_bus_fifo_if.sv
// Buffered CPU bus interface for the SPART: TX/RX FIFOs, baud divisor register
// pair, control/status with sticky error flags, and a level interrupt.

module spart_bus_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              drop_o
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: storage is not reset; pointers and count define validity, so clearing them discards contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

module spart_bus_fifo_if #(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int DIV_RESET = 325
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iocs,
  input  logic                iorw,
  input  logic [1:0]          ioaddr,
  input  logic [DATA_W-1:0]   databus_in,
  output logic [DATA_W-1:0]   databus_out,
  output logic                databus_sel,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic [2*DATA_W-1:0] divisor,
  output logic                div_load,
  output logic                irq
);
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_CTRL   = 2'b01,
    ADDR_DIV_LO = 2'b10,
    ADDR_DIV_HI = 2'b11
  } reg_addr_e;

  localparam logic [2*DATA_W-1:0] DIV_INIT = (2*DATA_W)'(DIV_RESET);

  reg_addr_e         addr;
  logic              cpu_rd, cpu_wr;
  logic              tx_push, tx_pop, tx_empty, tx_full, tx_drop;
  logic              rx_pop, rx_empty, rx_full, rx_drop;
  logic [DATA_W-1:0] rx_head, status;
  logic              sticky_clr;

  logic [DATA_W-1:0] div_lo_q, div_hi_q;
  logic              div_load_q;
  logic              rx_ie_q, tx_ie_q;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_overflow_q, tx_overflow_d;

  assign addr   = reg_addr_e'(ioaddr);
  assign cpu_rd = iocs && iorw;
  assign cpu_wr = iocs && !iorw;

  assign tx_push = cpu_wr && (addr == ADDR_DATA);
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_pop  = cpu_rd && (addr == ADDR_DATA);

  spart_bus_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (databus_in),
    .head_o  (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .drop_o  (tx_drop)
  );

  spart_bus_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .wdata_i (rx_data),
    .head_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .drop_o  (rx_drop)
  );

  assign tx_valid = !tx_empty;
  assign divisor  = {div_hi_q, div_lo_q};
  assign div_load = div_load_q;
  // Built only from registered state so the CPU bus cannot glitch it.
  assign irq      = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_empty);

  always_comb begin
    status    = '0;
    status[0] = !tx_full;
    status[1] = !rx_empty;
    status[2] = tx_empty;
    status[3] = rx_full;
    status[4] = rx_overrun_q;
    status[5] = tx_overflow_q;
    status[6] = irq;
  end

  always_comb begin
    databus_sel = cpu_rd;
    databus_out = '0;
    if (cpu_rd) begin
      unique case (addr)
        ADDR_DATA:   databus_out = rx_empty ? '0 : rx_head;
        ADDR_CTRL:   databus_out = status;
        ADDR_DIV_LO: databus_out = div_lo_q;
        ADDR_DIV_HI: databus_out = div_hi_q;
        default:     databus_out = '0;
      endcase
    end
  end

  assign sticky_clr = cpu_wr && (addr == ADDR_CTRL) && databus_in[2];

  // A new error in the clearing cycle keeps its flag set.
  always_comb begin
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    if (sticky_clr) begin
      rx_overrun_d  = 1'b0;
      tx_overflow_d = 1'b0;
    end
    if (rx_drop) rx_overrun_d  = 1'b1;
    if (tx_drop) tx_overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_lo_q      <= DIV_INIT[DATA_W-1:0];
      div_hi_q      <= DIV_INIT[2*DATA_W-1:DATA_W];
      div_load_q    <= 1'b0;
      rx_ie_q       <= 1'b0;
      tx_ie_q       <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      div_load_q    <= cpu_wr && (addr == ADDR_DIV_HI);
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      if (cpu_wr && (addr == ADDR_DIV_LO)) div_lo_q <= databus_in;
      if (cpu_wr && (addr == ADDR_DIV_HI)) div_hi_q <= databus_in;
      if (cpu_wr && (addr == ADDR_CTRL)) begin
        rx_ie_q <= databus_in[0];
        tx_ie_q <= databus_in[1];
      end
    end
  end
endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Directed self-checking bench for spart_bus_fifo_if: bus decode, both FIFOs,
// sticky flags, divisor registers, interrupt, and asynchronous reset.

module tb_spart_bus_fifo_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iocs = 1'b0;
  logic        iorw = 1'b0;
  logic [1:0]  ioaddr = 2'b00;
  logic [7:0]  databus_in = 8'h00;
  logic [7:0]  databus_out;
  logic        databus_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] divisor;
  logic        div_load;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  spart_bus_fifo_if #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .DIV_RESET(325)) dut (
    .clk         (clk),
    .rst         (rst),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .databus_in  (databus_in),
    .databus_out (databus_out),
    .databus_sel (databus_sel),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .divisor     (divisor),
    .div_load    (div_load),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // One clock of bus activity: drive at negedge, sample read data mid-cycle,
  // release just after the rising edge.
  task automatic bus_cycle(input logic cs, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input logic rxv, input logic [7:0] rxd,
                           output logic [7:0] q, output logic sel);
    @(negedge clk);
    iocs = cs; iorw = rw; ioaddr = a; databus_in = d;
    rx_valid = rxv; rx_data = rxd;
    #1;
    q = databus_out;
    sel = databus_sel;
    @(posedge clk);
    #1;
    iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q; logic s;
    bus_cycle(1'b1, 1'b0, a, d, 1'b0, 8'h00, q, s);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] q, output logic sel);
    bus_cycle(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, q, sel);
  endtask

  task automatic rx_push(input logic [7:0] d);
    logic [7:0] q; logic s;
    bus_cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, d, q, s);
  endtask

  task automatic test_reset;
    logic [7:0] q; logic s;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (databus_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel_idle: got %b want 0", databus_sel); end
    n_cmp++; if (databus_out !== 8'h00) begin n_err++; $display("FAIL reset_out_idle: got %h want 00", databus_out); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (div_load !== 1'b0) begin n_err++; $display("FAIL reset_div_load: got %b want 0", div_load); end
    n_cmp++; if (divisor !== 16'd325) begin n_err++; $display("FAIL reset_divisor: got %0d want 325", divisor); end
    rd(2'b01, q, s);
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL reset_status_sel: got %b want 1", s); end
    n_cmp++; if (q !== 8'h05) begin n_err++; $display("FAIL reset_status: got %h want 05", q); end
  endtask

  task automatic test_tx_fifo;
    logic [7:0] q; logic s;
    logic [7:0] exp_tx [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b0;
    wr(2'b00, 8'h11); wr(2'b00, 8'h22); wr(2'b00, 8'h33); wr(2'b00, 8'h44); wr(2'b00, 8'h55);
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h20) begin n_err++; $display("FAIL tx_overflow_status: got %h want 20", q); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[i]) begin
        n_err++; $display("FAIL tx_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_tx[i]);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained_valid: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    wr(2'b01, 8'h04);
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h05) begin n_err++; $display("FAIL tx_overflow_clear: got %h want 05", q); end
  endtask

  task automatic test_tx_full_push_pop;
    logic [7:0] q; logic s;
    logic [7:0] exp_tx [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
    tx_ready = 1'b0;
    wr(2'b00, 8'h61); wr(2'b00, 8'h62); wr(2'b00, 8'h63); wr(2'b00, 8'h64);
    tx_ready = 1'b1;
    wr(2'b00, 8'h65);
    tx_ready = 1'b0;
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL tx_full_push_pop_status: got %h want 00", q); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[i]) begin
        n_err++; $display("FAIL tx_full_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_tx[i]);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    tx_ready = 1'b1;
    wr(2'b00, 8'h77);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      n_err++; $display("FAIL tx_push_while_empty: got valid=%b data=%h want valid=1 data=77", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_push_while_empty_pop: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_fifo;
    logic [7:0] q; logic s;
    for (int i = 0; i < 5; i++) rx_push(8'hA0 + 8'(i));
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h1F) begin n_err++; $display("FAIL rx_overrun_status: got %h want 1f", q); end
    bus_cycle(1'b1, 1'b0, 2'b01, 8'h04, 1'b1, 8'hEE, q, s);
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h1F) begin n_err++; $display("FAIL sticky_set_beats_clear: got %h want 1f", q); end
    for (int i = 0; i < 4; i++) begin
      rd(2'b00, q, s);
      n_cmp++; if (s !== 1'b1 || q !== 8'hA0 + 8'(i)) begin
        n_err++; $display("FAIL rx_read[%0d]: got sel=%b data=%h want sel=1 data=%h", i, s, q, 8'hA0 + 8'(i));
      end
    end
    rd(2'b00, q, s);
    n_cmp++; if (s !== 1'b1 || q !== 8'h00) begin n_err++; $display("FAIL rx_read_empty: got sel=%b data=%h want sel=1 data=00", s, q); end
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h15) begin n_err++; $display("FAIL rx_empty_status: got %h want 15", q); end
    wr(2'b01, 8'h04);
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h05) begin n_err++; $display("FAIL rx_overrun_clear: got %h want 05", q); end
  endtask

  task automatic test_rx_full_read;
    logic [7:0] q; logic s;
    logic [7:0] exp_rx [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hB0};
    for (int i = 0; i < 4; i++) rx_push(8'hC0 + 8'(i));
    bus_cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'hB0, q, s);
    n_cmp++; if (q !== 8'hC0) begin n_err++; $display("FAIL rx_full_read_push: got %h want c0", q); end
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h0F) begin n_err++; $display("FAIL rx_full_read_push_status: got %h want 0f", q); end
    for (int i = 0; i < 4; i++) begin
      rd(2'b00, q, s);
      n_cmp++; if (q !== exp_rx[i]) begin n_err++; $display("FAIL rx_full_drain[%0d]: got %h want %h", i, q, exp_rx[i]); end
    end
    bus_cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'hD5, q, s);
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rx_empty_read_push: got %h want 00", q); end
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h07) begin n_err++; $display("FAIL rx_empty_read_push_status: got %h want 07", q); end
    rd(2'b00, q, s);
    n_cmp++; if (q !== 8'hD5) begin n_err++; $display("FAIL rx_empty_read_push_data: got %h want d5", q); end
  endtask

  task automatic test_divisor;
    logic [7:0] q; logic s;
    wr(2'b10, 8'h34);
    n_cmp++; if (divisor !== 16'h0134 || div_load !== 1'b0) begin
      n_err++; $display("FAIL div_low_write: got div=%h load=%b want div=0134 load=0", divisor, div_load);
    end
    wr(2'b11, 8'h12);
    n_cmp++; if (divisor !== 16'h1234 || div_load !== 1'b1) begin
      n_err++; $display("FAIL div_high_write: got div=%h load=%b want div=1234 load=1", divisor, div_load);
    end
    @(posedge clk); #1;
    n_cmp++; if (div_load !== 1'b0) begin n_err++; $display("FAIL div_load_single: got %b want 0", div_load); end
    rd(2'b10, q, s);
    n_cmp++; if (s !== 1'b1 || q !== 8'h34) begin n_err++; $display("FAIL div_low_read: got sel=%b data=%h want sel=1 data=34", s, q); end
    rd(2'b11, q, s);
    n_cmp++; if (s !== 1'b1 || q !== 8'h12) begin n_err++; $display("FAIL div_high_read: got sel=%b data=%h want sel=1 data=12", s, q); end
  endtask

  task automatic test_irq_and_reset;
    logic [7:0] q; logic s;
    wr(2'b01, 8'h03);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h45) begin n_err++; $display("FAIL irq_status: got %h want 45", q); end
    tx_ready = 1'b0;
    wr(2'b00, 8'h99);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_tx_pending: got %b want 0", irq); end
    rx_push(8'h5A);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rx_data: got %b want 1", irq); end
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h43) begin n_err++; $display("FAIL irq_rx_status: got %h want 43", q); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL async_reset_flags: got tx_valid=%b irq=%b want 0 0", tx_valid, irq);
    end
    n_cmp++; if (divisor !== 16'd325 || div_load !== 1'b0 || databus_sel !== 1'b0) begin
      n_err++; $display("FAIL async_reset_div: got div=%0d load=%b sel=%b want 325 0 0", divisor, div_load, databus_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    rd(2'b01, q, s);
    n_cmp++; if (q !== 8'h05) begin n_err++; $display("FAIL post_reset_status: got %h want 05", q); end
    rd(2'b00, q, s);
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL post_reset_rx_empty: got %h want 00", q); end
  endtask

  initial begin
    test_reset();
    test_tx_fifo();
    test_tx_full_push_pop();
    test_back_to_back();
    test_rx_fifo();
    test_rx_full_read();
    test_divisor();
    test_irq_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
